// File: rtl/jsv_spi_pkg.sv
// Shared definitions for the SPI transaction sequencer: core register map,
// the SSO control bit, FSM state encoding and the bus command payload.
package jsv_spi_pkg;

  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned SSO_BIT = 10;

  localparam logic [ADDR_W-1:0] ADDR_RXDATA   = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_TXDATA   = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_CONTROL  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_SLAVESEL = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_EOPVAL   = 3'd6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR,
    ST_SS_ON,
    ST_LOAD,
    ST_WAIT_RX,
    ST_RD,
    ST_HOLD,
    ST_SS_OFF,
    ST_FIN
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/jsv_spi_seq_if.sv
// Register-port signals between the sequencer (master) and the SPI core (slave).
interface jsv_spi_seq_if;
  import jsv_spi_pkg::*;

  logic              select;
  logic [ADDR_W-1:0] addr;
  logic              read_n;
  logic              write_n;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              readyfordata;
  logic              dataavailable;

  modport master (
    output select, addr, read_n, write_n, wdata,
    input  rdata, readyfordata, dataavailable
  );

  modport slave (
    input  select, addr, read_n, write_n, wdata,
    output rdata, readyfordata, dataavailable
  );
endinterface

// File: rtl/jsv_spi_bus_access.sv
// Single register access engine: two strobe cycles then one idle gap, so the
// core's edge-detected strobes fire exactly once per access.
module jsv_spi_bus_access
  import jsv_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  bus_req_t   cmd,
  output logic       ack,
  output logic [7:0] rdata,
  jsv_spi_seq_if.master spi
);

  typedef enum logic [1:0] {PH_IDLE, PH_ACC1, PH_ACC2, PH_GAP} phase_t;

  phase_t phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= PH_IDLE;
      ack         <= 1'b0;
      rdata       <= '0;
      spi.select  <= 1'b0;
      spi.read_n  <= 1'b1;
      spi.write_n <= 1'b1;
      spi.addr    <= '0;
      spi.wdata   <= '0;
    end else begin
      ack <= 1'b0;
      case (phase)
        PH_IDLE: begin
          if (req) begin
            phase       <= PH_ACC1;
            spi.select  <= 1'b1;
            spi.read_n  <= cmd.we;
            spi.write_n <= !cmd.we;
            spi.addr    <= cmd.addr;
            spi.wdata   <= cmd.wdata;
          end
        end
        PH_ACC1: phase <= PH_ACC2;
        PH_ACC2: begin
          // Read data is taken on the edge that closes the second strobe cycle.
          if (!spi.read_n) rdata <= spi.rdata[7:0];
          phase       <= PH_GAP;
          spi.select  <= 1'b0;
          spi.read_n  <= 1'b1;
          spi.write_n <= 1'b1;
          ack         <= 1'b1;
        end
        PH_GAP:  phase <= PH_IDLE;
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/jsv_spi_seq.sv
// Multi-byte SPI burst sequencer: drives the SPI core register port, streams
// TX/RX bytes and keeps slave-select forced on for the whole burst.
module jsv_spi_seq
  import jsv_spi_pkg::*;
#(
  parameter int unsigned LEN_W    = 5,
  parameter logic [15:0] CTRL_SSO = 16'h0400
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  jsv_spi_seq_if.master    spi
);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             req;
  logic             issued;
  logic             ack;
  bus_req_t         cmd;

  jsv_spi_bus_access u_bus (
    .clk   (clk),
    .rst_n (reset_n),
    .req   (req),
    .cmd   (cmd),
    .ack   (ack),
    .rdata (rx_data),
    .spi   (spi)
  );

  // Each bus state issues one command (issued) and leaves on the engine's ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      req       <= 1'b0;
      issued    <= 1'b0;
      cmd       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tx_ready  <= 1'b0;
      rx_valid  <= 1'b0;
    end else begin
      req      <= 1'b0;
      done     <= 1'b0;
      tx_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len != '0) begin
              remaining <= len;
              busy      <= 1'b1;
              state     <= ST_CLR;
            end else begin
              done  <= 1'b1;
              state <= ST_FIN;
            end
          end
        end
        ST_CLR: begin
          if (!issued) begin
            req    <= 1'b1;
            issued <= 1'b1;
            cmd    <= '{we: 1'b1, addr: ADDR_STATUS, wdata: 16'h0000};
          end else if (ack) begin
            issued <= 1'b0;
            state  <= ST_SS_ON;
          end
        end
        ST_SS_ON: begin
          if (!issued) begin
            req    <= 1'b1;
            issued <= 1'b1;
            cmd    <= '{we: 1'b1, addr: ADDR_CONTROL, wdata: CTRL_SSO};
          end else if (ack) begin
            issued <= 1'b0;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!issued) begin
            if (tx_valid && spi.readyfordata) begin
              req       <= 1'b1;
              issued    <= 1'b1;
              cmd       <= '{we: 1'b1, addr: ADDR_TXDATA, wdata: {8'h00, tx_data}};
              remaining <= remaining - LEN_W'(1);
            end
          end else begin
            // req is high exactly one cycle, so this lands in strobe cycle 1.
            if (req) tx_ready <= 1'b1;
            if (ack) begin
              issued <= 1'b0;
              state  <= ST_WAIT_RX;
            end
          end
        end
        ST_WAIT_RX: begin
          if (spi.dataavailable) state <= ST_RD;
        end
        ST_RD: begin
          if (!issued) begin
            req    <= 1'b1;
            issued <= 1'b1;
            cmd    <= '{we: 1'b0, addr: ADDR_RXDATA, wdata: 16'h0000};
          end else if (ack) begin
            issued   <= 1'b0;
            rx_valid <= 1'b1;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (rx_ready) begin
            rx_valid <= 1'b0;
            state    <= (remaining != '0) ? ST_LOAD : ST_SS_OFF;
          end
        end
        ST_SS_OFF: begin
          if (!issued) begin
            req    <= 1'b1;
            issued <= 1'b1;
            cmd    <= '{we: 1'b1, addr: ADDR_CONTROL, wdata: 16'h0000};
          end else if (ack) begin
            issued <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_FIN;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
